// File: rtl/signed_sum_accumulator.sv
// Accumulates blocks of COUNT signed samples into a saturating ACC_W-bit total
// and presents each block total on a valid/ready output until it is consumed.
module signed_sum_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               sat_reg, sat_next;
  logic [ACC_W-1:0]   out_sum_reg, out_sum_next;
  logic               out_sat_reg, out_sat_next;
  logic               out_valid_reg, out_valid_next;
  logic               busy_reg, busy_next;

  logic [ACC_W-1:0]   ext;
  logic [ACC_W-1:0]   raw;
  logic [ACC_W-1:0]   stepped;
  logic               ovf;
  logic               accept;
  logic               last;

  // Sign extension of the incoming sample to accumulator width.
  generate
    for (genvar gi = 0; gi < ACC_W; gi++) begin : g_ext
      if (gi < DATA_W) begin : g_low
        assign ext[gi] = in_data[gi];
      end else begin : g_high
        assign ext[gi] = in_data[DATA_W-1];
      end
    end
  endgenerate

  assign raw = acc_reg + ext;
  // Overflow only when both operands share a sign that the raw sum lost.
  assign ovf = (acc_reg[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc_reg[ACC_W-1]);
  assign stepped = !ovf ? raw :
                   acc_reg[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};

  assign in_ready = (state_reg != DONE);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt_reg == CNT_W'(COUNT - 1));

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    sat_next       = sat_reg;
    out_sum_next   = out_sum_reg;
    out_sat_next   = out_sat_reg;
    out_valid_next = out_valid_reg;
    if (clear) begin
      state_next     = IDLE;
      acc_next       = '0;
      cnt_next       = '0;
      sat_next       = 1'b0;
      out_valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE, ACCUM: begin
          if (accept) begin
            if (last) begin
              state_next     = DONE;
              out_sum_next   = stepped;
              out_sat_next   = sat_reg | ovf;
              out_valid_next = 1'b1;
              acc_next       = '0;
              cnt_next       = '0;
              sat_next       = 1'b0;
            end else begin
              state_next = ACCUM;
              acc_next   = stepped;
              cnt_next   = cnt_reg + CNT_W'(1);
              sat_next   = sat_reg | ovf;
            end
          end
        end
        DONE: begin
          if (out_valid_reg && out_ready) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      sat_reg       <= 1'b0;
      out_sum_reg   <= '0;
      out_sat_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      sat_reg       <= sat_next;
      out_sum_reg   <= out_sum_next;
      out_sat_reg   <= out_sat_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
    end
  end

  assign out_sum   = out_sum_reg;
  assign out_sat   = out_sat_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_signed_sum_accumulator.sv
// Self-checking bench: three accumulator configurations share one stimulus stream
// and are checked every cycle against a block-level saturating-sum model.
module tb_signed_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic [2:0]  ir_v, ov_v, st_v, bz_v;
  logic [15:0] sum0, sum2;
  logic [8:0]  sum1;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  // ch0: defaults, ch1: ACC_W=9, ch2: COUNT=1
  signed_sum_accumulator #(.DATA_W(8), .ACC_W(16), .COUNT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir_v[0]), .out_sum(sum0), .out_sat(st_v[0]), .out_valid(ov_v[0]),
    .out_ready(out_ready), .busy(bz_v[0]));
  signed_sum_accumulator #(.DATA_W(8), .ACC_W(9), .COUNT(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir_v[1]), .out_sum(sum1), .out_sat(st_v[1]), .out_valid(ov_v[1]),
    .out_ready(out_ready), .busy(bz_v[1]));
  signed_sum_accumulator #(.DATA_W(8), .ACC_W(16), .COUNT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir_v[2]), .out_sum(sum2), .out_sat(st_v[2]), .out_valid(ov_v[2]),
    .out_ready(out_ready), .busy(bz_v[2]));

  // Reference model state per channel
  int     accw [3] = '{16, 9, 16};
  int     cnt  [3] = '{4, 4, 1};
  bit     m_pend [3];
  longint m_sum [3];
  bit     m_sat [3];
  int     m_n [3];
  longint m_smp [3][256];

  function automatic longint act_sum(int ch);
    if (ch == 0) return longint'($signed(sum0));
    if (ch == 1) return longint'($signed(sum1));
    return longint'($signed(sum2));
  endfunction

  task automatic chk(string name, longint act, longint exp);
    ntotal++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else npass++;
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      m_pend[ch] = 0; m_n[ch] = 0; m_sat[ch] = 0; m_sum[ch] = 0;
    end
  endtask

  // Block total: integer running sum clamped to the signed ACC_W range at each step.
  task automatic model_total(int ch);
    longint mx, mn, s;
    bit sat;
    mx = (longint'(1) <<< (accw[ch] - 1)) - 1;
    mn = -mx - 1;
    s = 0; sat = 0;
    for (int i = 0; i < cnt[ch]; i++) begin
      s += m_smp[ch][i];
      if (s > mx) begin s = mx; sat = 1; end
      else if (s < mn) begin s = mn; sat = 1; end
    end
    m_sum[ch] = s;
    m_sat[ch] = sat;
  endtask

  task automatic model_edge();
    for (int ch = 0; ch < 3; ch++) begin
      if (clear) begin
        m_n[ch] = 0; m_pend[ch] = 0;
      end else if (m_pend[ch]) begin
        if (out_ready) m_pend[ch] = 0;
      end else if (in_valid) begin
        m_smp[ch][m_n[ch]] = longint'($signed(in_data));
        m_n[ch]++;
        if (m_n[ch] == cnt[ch]) begin
          model_total(ch);
          m_pend[ch] = 1;
          m_n[ch] = 0;
        end
      end
    end
  endtask

  task automatic model_check();
    for (int ch = 0; ch < 3; ch++) begin
      chk($sformatf("ch%0d in_ready", ch), longint'(ir_v[ch]), longint'(!m_pend[ch]));
      chk($sformatf("ch%0d out_valid", ch), longint'(ov_v[ch]), longint'(m_pend[ch]));
      chk($sformatf("ch%0d busy", ch), longint'(bz_v[ch]), longint'(m_pend[ch] || m_n[ch] > 0));
      if (m_pend[ch]) begin
        chk($sformatf("ch%0d out_sum", ch), act_sum(ch), m_sum[ch]);
        chk($sformatf("ch%0d out_sat", ch), longint'(st_v[ch]), longint'(m_sat[ch]));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic feed(int x);
    in_valid = 1'b1;
    in_data  = 8'(x);
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values(string tag);
    for (int ch = 0; ch < 3; ch++) begin
      chk($sformatf("%s ch%0d in_ready", tag, ch), longint'(ir_v[ch]), 1);
      chk($sformatf("%s ch%0d out_valid", tag, ch), longint'(ov_v[ch]), 0);
      chk($sformatf("%s ch%0d out_sum", tag, ch), act_sum(ch), 0);
      chk($sformatf("%s ch%0d out_sat", tag, ch), longint'(st_v[ch]), 0);
      chk($sformatf("%s ch%0d busy", tag, ch), longint'(bz_v[ch]), 0);
    end
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic pulse_reset(string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       e_ov;
    int         e_sum;
    logic       e_ir;
    logic       e_busy;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int ones;

    tbl[0] = '{v: 1'b1, d: 8'd10,  rdy: 1'b1, e_ov: 1'b0, e_sum: 0, e_ir: 1'b1, e_busy: 1'b1};
    tbl[1] = '{v: 1'b1, d: 8'hFD,  rdy: 1'b1, e_ov: 1'b0, e_sum: 0, e_ir: 1'b1, e_busy: 1'b1};
    tbl[2] = '{v: 1'b1, d: 8'h7F,  rdy: 1'b1, e_ov: 1'b0, e_sum: 0, e_ir: 1'b1, e_busy: 1'b1};
    tbl[3] = '{v: 1'b1, d: 8'h80,  rdy: 1'b1, e_ov: 1'b1, e_sum: 6, e_ir: 1'b0, e_busy: 1'b1};
    tbl[4] = '{v: 1'b0, d: 8'h00,  rdy: 1'b1, e_ov: 1'b0, e_sum: 0, e_ir: 1'b1, e_busy: 1'b0};

    model_reset();
    @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal block 10, -3, 127, -128 with out_ready high
    for (int i = 0; i < 5; i++) begin
      in_valid  = tbl[i].v;
      in_data   = tbl[i].d;
      out_ready = tbl[i].rdy;
      step();
      chk($sformatf("nom[%0d] out_valid", i), longint'(ov_v[0]), longint'(tbl[i].e_ov));
      chk($sformatf("nom[%0d] in_ready", i), longint'(ir_v[0]), longint'(tbl[i].e_ir));
      chk($sformatf("nom[%0d] busy", i), longint'(bz_v[0]), longint'(tbl[i].e_busy));
      if (tbl[i].e_ov) begin
        chk($sformatf("nom[%0d] out_sum", i), act_sum(0), longint'(tbl[i].e_sum));
        chk($sformatf("nom[%0d] out_sat", i), longint'(st_v[0]), 0);
      end
    end
    in_valid = 1'b0;

    // Saturation on the 9-bit channel, then sticky flag clears
    pulse_reset("sat_rst");
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) feed(127);
    chk("sat_pos sum", act_sum(1), 255);
    chk("sat_pos flag", longint'(st_v[1]), 1);
    step();
    for (int i = 0; i < 4; i++) feed(-128);
    chk("sat_neg sum", act_sum(1), -256);
    chk("sat_neg flag", longint'(st_v[1]), 1);
    step();
    for (int i = 0; i < 4; i++) feed(1);
    chk("sat_clr sum", act_sum(1), 4);
    chk("sat_clr flag", longint'(st_v[1]), 0);
    step();

    // Backpressure: result held, sample 99 refused while stalled
    pulse_reset("bp_rst");
    out_ready = 1'b0;
    feed(1); feed(2); feed(1); feed(2);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd99;
      step();
      chk($sformatf("bp[%0d] out_sum", i), act_sum(0), 6);
      chk($sformatf("bp[%0d] out_valid", i), longint'(ov_v[0]), 1);
      chk($sformatf("bp[%0d] in_ready", i), longint'(ir_v[0]), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp release out_valid", longint'(ov_v[0]), 0);
    chk("bp release in_ready", longint'(ir_v[0]), 1);
    chk("bp release busy", longint'(bz_v[0]), 0);

    // Stalled input: gaps of two idle cycles between samples
    for (int i = 0; i < 4; i++) begin
      feed(5);
      if (i < 3) begin
        chk($sformatf("stall[%0d] out_valid", i), longint'(ov_v[0]), 0);
        step(); step();
      end
    end
    chk("stall out_valid", longint'(ov_v[0]), 1);
    chk("stall out_sum", act_sum(0), 20);
    step();

    // clear mid-block, with a sample offered in the clear cycle
    feed(50); feed(50);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd77;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear busy", longint'(bz_v[0]), 0);
    chk("clear out_valid", longint'(ov_v[0]), 0);
    feed(1); feed(2); feed(3); feed(4);
    chk("after clear sum", act_sum(0), 10);
    step();

    // Reset mid-block
    feed(1); feed(2);
    pulse_reset("mid_rst");
    feed(1); feed(2); feed(3); feed(4);
    chk("after rst sum", act_sum(0), 10);
    step();

    // COUNT=1 channel
    pulse_reset("c1_rst");
    out_ready = 1'b1;
    feed(-7);
    chk("c1 out_valid", longint'(ov_v[2]), 1);
    chk("c1 out_sum", act_sum(2), -7);
    in_valid = 1'b1;
    in_data  = 8'd3;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ov_v[2]) ones++;
    end
    in_valid = 1'b0;
    chk("c1 results in 8 cycles", longint'(ones), 4);
    step();

    // Randomized traffic against the model
    pulse_reset("rnd_rst");
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 63) == 0);
      step();
    end
    clear = 1'b0; in_valid = 1'b0;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
